uart_tx_buffer: RTL and testbench

Transmit-side buffer and sequencer that sits directly upstream of the UART core. It accepts bytes from the host through a write-strobe interface, stores them in a circular FIFO, and feeds them one at a time to the core over its `start_tx` / `tx_data` / `tx_done` handshake. It also reports fill level and flags overflow.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_buffer.sv | 88 ++++++++
 tb/tb_uart_tx_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmit-buffer sequencer states.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StGap   = 2'd3
  } tx_buf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with wrap-bit pointers, registered status flags and a sticky overflow flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = UART_DATA_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             do_wr, do_rd;

  // Status comes straight from the pointer registers, so it reflects the previous edge only.
  assign full_o     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_wr      = wr_en_i && !full_o && !flush_i;
    do_rd      = rd_en_i && !empty_o && !flush_i;
    wr_ptr_d   = wr_ptr_q + PW'(do_wr);
    rd_ptr_d   = rd_ptr_q + PW'(do_rd);
    overflow_d = overflow_q;
    if (flush_i) begin
      rd_ptr_d   = wr_ptr_q;
      overflow_d = 1'b0;
    end else if (wr_en_i && full_o) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer: host write FIFO plus a sequencer that hands bytes to the UART core one at a time.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   almost_full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   busy,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   start_tx,
  input  logic                   tx_done
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] AfullLvl = LW'(AFULL_LVL);

  tx_buf_state_e          state_q, state_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [UART_DATA_W-1:0] fifo_head;
  logic                   pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (pop),
    .flush_i    (flush),
    .rd_data_o  (fifo_head),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow)
  );

  assign almost_full = (level >= AfullLvl);
  assign busy        = (state_q != StIdle);
  assign start_tx    = (state_q == StStart);
  assign tx_data     = tx_data_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !flush) begin
          pop       = 1'b1;
          tx_data_d = fifo_head;
          state_d   = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (tx_done) begin
          state_d = StGap;
        end
      end
      // Spacer cycle so a new start_tx can never land on the core's tx_done.
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_done = 1'b0;
  logic       full, almost_full, empty, overflow, busy, start_tx;
  logic [4:0] level;
  logic [7:0] tx_data;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_tx_buffer #(
    .DEPTH     (16),
    .AFULL_LVL (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .busy        (busy),
    .tx_data     (tx_data),
    .start_tx    (start_tx),
    .tx_done     (tx_done)
  );

  // Inputs in a record are applied for one cycle; expectations are the outputs in the next cycle.
  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic       done;
    logic       st;
    logic [7:0] txd;
    logic [4:0] lvl;
    logic       emp;
    logic       bsy;
    logic       ful;
    logic       af;
    logic       ovf;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".level"}, 32'(level), 32'd0);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".afull"}, 32'(almost_full), 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".start"}, 32'(start_tx), 32'd0);
    chk({tag, ".txd"}, 32'(tx_data), 32'd0);
  endtask

  task automatic hard_reset();
    wr_en   = 1'b0;
    flush   = 1'b0;
    tx_done = 1'b0;
    reset_n = 1'b0;
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  int         starts [$];
  logic [7:0] sdata  [$];
  int         done_at;

  initial begin
    //            wr    d      fl    done  | st    txd    lvl   emp   bsy   ful   af    ovf
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Write lands on the same edge as the IDLE pop: level stays at 1.
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // tx_done during START is ignored; the sequencer still waits for a real one.
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    // Flush beats a same-cycle write in IDLE: nothing stored, nothing sent.
    vecs[15] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values while reset is held.
    step();
    chk_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].d;
      flush   = vecs[i].fl;
      tx_done = vecs[i].done;
      step();
      chk($sformatf("v%0d.start", i), 32'(start_tx), 32'(vecs[i].st));
      chk($sformatf("v%0d.txd", i), 32'(tx_data), 32'(vecs[i].txd));
      chk($sformatf("v%0d.level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("v%0d.full", i), 32'(full), 32'(vecs[i].ful));
      chk($sformatf("v%0d.afull", i), 32'(almost_full), 32'(vecs[i].af));
      chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end
    wr_en   = 1'b0;
    flush   = 1'b0;
    tx_done = 1'b0;
    step();

    // Burst of four bytes; core model answers tx_done 10 cycles after each start_tx.
    hard_reset();
    done_at = -1;
    for (int c = 0; c < 80; c++) begin
      if (start_tx) begin
        starts.push_back(c);
        sdata.push_back(tx_data);
        done_at = c + 10;
      end
      wr_en   = (c < 4);
      wr_data = 8'(c + 1);
      tx_done = (c == done_at);
      step();
    end
    wr_en   = 1'b0;
    tx_done = 1'b0;
    chk("burst.count", 32'(starts.size()), 32'd4);
    for (int i = 0; i < starts.size(); i++) begin
      chk($sformatf("burst.data%0d", i), 32'(sdata[i]), 32'(i + 1));
      if (i == 0) chk("burst.first", 32'(starts[0]), 32'd2);
      else chk($sformatf("burst.gap%0d", i), 32'(starts[i] - starts[i-1]), 32'd13);
    end
    chk("burst.busy", 32'(busy), 32'd0);
    chk("burst.empty", 32'(empty), 32'd1);

    // Fill to full with tx_done withheld, overflow on a write that coincides with a pop, then flush.
    hard_reset();
    for (int c = 0; c <= 30; c++) begin
      if (c == 2) begin
        chk("fill.start2", 32'(start_tx), 32'd1);
        chk("fill.txd2", 32'(tx_data), 32'h10);
      end
      if (c == 12) begin
        chk("fill.lvl12", 32'(level), 32'd11);
        chk("fill.af12", 32'(almost_full), 32'd0);
      end
      if (c == 13) begin
        chk("fill.lvl13", 32'(level), 32'd12);
        chk("fill.af13", 32'(almost_full), 32'd1);
      end
      if (c == 16) chk("fill.full16", 32'(full), 32'd0);
      if (c == 17) begin
        chk("fill.full17", 32'(full), 32'd1);
        chk("fill.lvl17", 32'(level), 32'd16);
        chk("fill.ovf17", 32'(overflow), 32'd0);
      end
      if (c == 19) begin
        chk("fill.full19", 32'(full), 32'd1);
        chk("fill.busy19", 32'(busy), 32'd0);
      end
      if (c == 20) begin
        chk("fill.lvl20", 32'(level), 32'd15);
        chk("fill.ovf20", 32'(overflow), 32'd1);
        chk("fill.full20", 32'(full), 32'd0);
        chk("fill.start20", 32'(start_tx), 32'd1);
        chk("fill.txd20", 32'(tx_data), 32'h11);
      end
      if (c == 21) chk("flush.busy21", 32'(busy), 32'd1);
      if (c == 22) begin
        chk("flush.lvl22", 32'(level), 32'd0);
        chk("flush.empty22", 32'(empty), 32'd1);
        chk("flush.ovf22", 32'(overflow), 32'd0);
        chk("flush.busy22", 32'(busy), 32'd1);
        chk("flush.txd22", 32'(tx_data), 32'h11);
      end
      if (c == 24) chk("flush.busy24", 32'(busy), 32'd0);
      if (c >= 23) chk($sformatf("flush.nostart%0d", c), 32'(start_tx), 32'd0);
      wr_en   = (c <= 16) || (c == 19) || (c == 21);
      wr_data = 8'(8'h10 + c);
      tx_done = (c == 17) || (c == 22);
      flush   = (c == 21);
      step();
    end
    wr_en   = 1'b0;
    tx_done = 1'b0;
    flush   = 1'b0;

    // Asynchronous reset in WAIT with bytes queued, then normal latency afterwards.
    hard_reset();
    for (int c = 0; c < 4; c++) begin
      wr_en   = (c < 3);
      wr_data = 8'(8'h40 + c);
      step();
    end
    wr_en = 1'b0;
    chk("arst.busy_pre", 32'(busy), 32'd1);
    chk("arst.lvl_pre", 32'(level), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    wr_en   = 1'b1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    chk("arst.lvl1", 32'(level), 32'd1);
    chk("arst.start1", 32'(start_tx), 32'd0);
    step();
    chk("arst.start2", 32'(start_tx), 32'd1);
    chk("arst.txd2", 32'(tx_data), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
